sync_count_monitor: RTL

Receive-side checker for the synchronous up/down counter's output bus. Samples the counter value each enabled cycle and recovers the counting direction. Flags illegal steps, wrap-around events and (optionally) stalls, and keeps a saturating error tally. Sits beside the counter in benches and integrated designs as the consumer of `q`.

---
 rtl/sync_count_monitor_pkg.sv | 19 +
 rtl/count_step_classifier.sv | 33 +++
 rtl/sync_count_monitor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sync_count_monitor_pkg.sv
// Shared types for the up/down counter monitor: FSM states and step classes.
// Imported by count_step_classifier and sync_count_monitor.
package sync_count_monitor_pkg;

    typedef enum logic [1:0] {
        SEED,
        ACQUIRE,
        UP,
        DOWN
    } mon_state_e;

    typedef enum logic [1:0] {
        UP_STEP,
        DOWN_STEP,
        HOLD,
        ILLEGAL
    } step_class_e;

endpackage

// File: rtl/count_step_classifier.sv
// Combinational step classifier: compares the new count against the previous one
// (modulo 2^WIDTH) and reports the step class and whether the step wrapped.
module count_step_classifier
    import sync_count_monitor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] q_i,
    output step_class_e      step_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] delta;

    assign delta = q_i - prev_i;

    // A wrap is only meaningful for a legal single step across the max/zero boundary.
    always_comb begin
        step_o = ILLEGAL;
        wrap_o = 1'b0;
        if (delta == WIDTH'(1)) begin
            step_o = UP_STEP;
            wrap_o = &prev_i;
        end else if (&delta) begin
            step_o = DOWN_STEP;
            wrap_o = ~|prev_i;
        end else if (delta == '0) begin
            step_o = HOLD;
        end
    end

endmodule

// File: rtl/sync_count_monitor.sv
// Receive-side checker for an up/down counter bus: recovers direction, flags illegal
// steps and wraps, tallies errors. Stall detection is built only with SYNC_COUNT_MON_STALL_DETECT_EN.
module sync_count_monitor
    import sync_count_monitor_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int STALL_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     q_in,
    output logic                 locked,
    output logic                 dir_up,
    output logic                 step_err,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 stalled
);

    if (WIDTH < 2 || WIDTH > 16 || ERR_CNT_W < 1 || STALL_LIMIT < 1) begin : g_bad_params
        $error("sync_count_monitor: illegal parameter combination");
    end

    mon_state_e           state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 locked_q, locked_d;
    logic                 dirUp_q, dirUp_d;
    logic                 stepErr_q, stepErr_d;
    logic                 wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0] errCount_q, errCount_d;
    step_class_e          stepClass;
    logic                 stepWrap;

    count_step_classifier #(.WIDTH(WIDTH)) u_classifier (
        .prev_i (prev_q),
        .q_i    (q_in),
        .step_o (stepClass),
        .wrap_o (stepWrap)
    );

    // Direction tracking; an illegal step from a locked state forces re-acquisition.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        stepErr_d  = 1'b0;
        wrap_d     = 1'b0;
        errCount_d = errCount_q;
        if (sample_en) begin
            prev_d = q_in;
            if (state_q == SEED) begin
                state_d = ACQUIRE;
            end else begin
                wrap_d = stepWrap;
                unique case (stepClass)
                    UP_STEP:   state_d = UP;
                    DOWN_STEP: state_d = DOWN;
                    HOLD:      state_d = state_q;
                    ILLEGAL: begin
                        stepErr_d = 1'b1;
                        state_d   = ACQUIRE;
                    end
                    default:   state_d = state_q;
                endcase
            end
        end
        if (stepErr_d && !(&errCount_q)) begin
            errCount_d = errCount_q + ERR_CNT_W'(1);
        end
        locked_d = (state_d == UP) || (state_d == DOWN);
        dirUp_d  = (state_d == UP) ? 1'b1 : (state_d == DOWN) ? 1'b0 : dirUp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEED;
            prev_q     <= '0;
            locked_q   <= 1'b0;
            dirUp_q    <= 1'b1;
            stepErr_q  <= 1'b0;
            wrap_q     <= 1'b0;
            errCount_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            locked_q   <= locked_d;
            dirUp_q    <= dirUp_d;
            stepErr_q  <= stepErr_d;
            wrap_q     <= wrap_d;
            errCount_q <= errCount_d;
        end
    end

`ifdef SYNC_COUNT_MON_STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] stallCnt_q, stallCnt_d;
    logic               stalled_q, stalled_d;

    // Counter saturates at the limit so stalled stays up until the count moves again.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (sample_en) begin
            if (stepClass == HOLD && (state_q == UP || state_q == DOWN)) begin
                if (stallCnt_q != STALL_W'(STALL_LIMIT)) begin
                    stallCnt_d = stallCnt_q + STALL_W'(1);
                end
            end else begin
                stallCnt_d = '0;
            end
        end
        stalled_d = (stallCnt_d >= STALL_W'(STALL_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= '0;
            stalled_q  <= 1'b0;
        end else begin
            stallCnt_q <= stallCnt_d;
            stalled_q  <= stalled_d;
        end
    end

    assign stalled = stalled_q;
`else
    assign stalled = 1'b0;
`endif

    assign locked    = locked_q;
    assign dir_up    = dirUp_q;
    assign step_err  = stepErr_q;
    assign wrap      = wrap_q;
    assign err_count = errCount_q;

endmodule
